indec_stream: RTL and testbench
===============================

// Module: indec_stream
// PURPOSE
//  Parametrised SUMP instruction decoder that consumes the raw UART byte stream itself.
//  Assembles 1-byte short and 5-byte long commands (opcode, then 4 argument bytes LSB first).
//  Decodes them into one-cycle strobes plus a registered argument and trigger-stage index.
//  Adds a configurable stage count, an inter-byte timeout, unknown-opcode and bad-stage
//  error reporting. Sits between uart_rx and the trigger/sampler/transmitter control.
// PARAMETERS
//  STAGES   4     trigger stages decoded, 1..16; stage field is opc[2+:STG_W]
//  TMO_CYC  1000  idle cycles between argument bytes before a long command is dropped; 0 = no timeout
//  STG_W    $clog2(STAGES) (min 1), localparam, width of stg_o
// PORTS
//  clk_i      in   1      system clock
//  rst_in     in   1      synchronous reset, active low
//  rx_stb_i   in   1      one-cycle strobe, rx_dat_i valid
//  rx_dat_i   in   8      received byte
//  sht_stb_o  out  9      short-command strobes, bit map below
//  lng_stb_o  out  8      long-command strobes, bit map below
//  cmd_o      out  32     argument of last long command, held until next long command
//  stg_o      out  STG_W  stage index of last stage-qualified long command, held
//  stb_o      out  1      OR of all sht_stb_o/lng_stb_o bits
//  err_o      out  1      one-cycle pulse: unknown opcode, stage >= STAGES, or timeout
//  busy_o     out  1      high while argument bytes are being collected
// BEHAVIOUR
//  - Sync reset (rst_in=0 at posedge): state IDLE, byte count 0, timer 0. All strobes,
//    err_o and busy_o are 0. cmd_o=0 and stg_o=0. Reset overrides any byte in flight.
//  - Short map (sht_stb_o[0..8]): 00 sft_rst, 01 arm, 02 id, 04 rd_meta, 05 fin_now,
//    06 rd_inp, 0F arm_adv, 11 xon, 13 xoff.
//  - Long map (lng_stb_o[0..7]): set_mask, set_val, set_cfg (opc[7:6]=11, opc[1:0]=0/1/2),
//    set_div 80, set_cnt 81, set_flgs 82, set_adv_cfg 9E, set_adv_dat 9F.
//  - FSM IDLE: on rx_stb_i, if rx_dat_i[7]=0 then decode as short. A known opcode pulses
//    the mapped bit and stb_o on the next cycle (latency 1). An unknown opcode pulses err_o.
//    If rx_dat_i[7]=1, latch the opcode, cnt=0, timer=0 and go to ARG. busy_o=1 from the
//    next cycle.
//  - ARG: each rx_stb_i shifts rx_dat_i into arg[8*cnt+:8] and increments cnt. timer is
//    cleared on every byte and incremented otherwise.
//  - On the 4th argument byte, return to IDLE. Next cycle: cmd_o<=arg and decode the
//    opcode. For a known long opcode, pulse the mapped bit and stb_o. For C0..FF, also
//    load stg_o<=opc[2+:STG_W].
//  - Error conditions: an unknown long opcode pulses err_o only. A C0..FF opcode with
//    opc[5:2] >= STAGES, or opc[1:0]=3, pulses err_o only. In both cases cmd_o and stg_o
//    are unchanged.
//  - Timeout: in ARG with TMO_CYC>0, when timer reaches TMO_CYC-1 with no rx_stb_i, go to
//    IDLE, pulse err_o and discard the partial argument. A byte arriving on that same cycle
//    wins (it is accepted, no timeout).
//  - Strobes are at most one cycle wide; at most one strobe bit plus stb_o per cycle.
//    A byte can be accepted every cycle with no back-pressure.
//  - A 0x00 byte during ARG is argument data, not a reset. Five 0x00 bytes in IDLE give
//    five sft_rst pulses.
//  - sft_rst does not reset this block.
// TESTING
//  - Send 0x02 -> sht_stb_o=9'h004 and stb_o=1 for exactly 1 cycle, 1 cycle after rx_stb_i; cmd_o unchanged.
//  - Send C4 78 56 34 12 (STAGES=4) -> lng_stb_o[0]=1 for 1 cycle, cmd_o=32'h12345678, stg_o=1; busy_o high between bytes.
//  - STAGES=2, send D0 + 4 bytes -> err_o pulse only, no lng_stb_o, stg_o/cmd_o unchanged.
//  - Send 81 AA, then idle TMO_CYC cycles -> err_o pulse, busy_o=0; then 0x01 -> sht_stb_o[1] pulse.
//  - Send 80 + 2 bytes, assert rst_in=0 for 1 cycle, then 80 01 00 00 00 -> set_div pulse, cmd_o=1.
//  - Send 0x03, then 0xA5 + 4 back-to-back bytes -> two err_o pulses, no strobes.

Source files
------------

// File: rtl/indec_stream.sv
// indec_stream: SUMP instruction decoder fed directly from the UART byte stream.
// Assembles 1-byte short commands and 5-byte long commands (opcode + 4 argument
// bytes, LSB first) and turns them into one-cycle strobes, a held 32-bit argument
// and a held trigger-stage index.
//
// state | meaning
// IDLE  | waiting for an opcode byte; short opcodes decode immediately
// ARG   | long opcode latched, collecting 4 argument bytes, inter-byte timer running
//
// Ports:
//   clk_i      system clock
//   rst_in     synchronous reset, active low
//   rx_stb_i   one-cycle strobe, rx_dat_i valid
//   rx_dat_i   received byte
//   sht_stb_o  short-command strobes (sft_rst, arm, id, rd_meta, fin_now, rd_inp, arm_adv, xon, xoff)
//   lng_stb_o  long-command strobes (set_mask, set_val, set_cfg, set_div, set_cnt, set_flgs, set_adv_cfg, set_adv_dat)
//   cmd_o      argument of the last accepted long command
//   stg_o      stage index of the last accepted stage-qualified long command
//   stb_o      OR of all command strobes
//   err_o      one-cycle pulse on unknown opcode, bad stage or inter-byte timeout
//   busy_o     high while argument bytes are being collected
module indec_stream #(
    parameter int  STAGES  = 4,
    parameter int  TMO_CYC = 1000,
    localparam int STG_W   = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             rx_stb_i,
    input  logic [7:0]       rx_dat_i,
    output logic [8:0]       sht_stb_o,
    output logic [7:0]       lng_stb_o,
    output logic [31:0]      cmd_o,
    output logic [STG_W-1:0] stg_o,
    output logic             stb_o,
    output logic             err_o,
    output logic             busy_o
);
    localparam int         TW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam int         TMO_LAST = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;
    localparam logic [4:0] STAGES_L = 5'(STAGES);

    typedef enum logic {IDLE = 1'b0, ARG = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [7:0]       opc_q, opc_d;
    logic [23:0]      arg_q, arg_d;
    logic [31:0]      cmd_q, cmd_d;
    logic [STG_W-1:0] stg_q, stg_d;
    logic [8:0]       sht_q, sht_d;
    logic [7:0]       lng_q, lng_d;
    logic             err_q, err_d;
    logic [31:0]      full_arg;

    // Bytes shift in from the top, so after three bytes arg_q holds {b2,b1,b0}
    // and the fourth byte completes the little-endian word.
    assign full_arg = {rx_dat_i, arg_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        opc_d   = opc_q;
        arg_d   = arg_q;
        cmd_d   = cmd_q;
        stg_d   = stg_q;
        sht_d   = '0;
        lng_d   = '0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_stb_i) begin
                    if (!rx_dat_i[7]) begin
                        case (rx_dat_i)
                            8'h00:   sht_d[0] = 1'b1;
                            8'h01:   sht_d[1] = 1'b1;
                            8'h02:   sht_d[2] = 1'b1;
                            8'h04:   sht_d[3] = 1'b1;
                            8'h05:   sht_d[4] = 1'b1;
                            8'h06:   sht_d[5] = 1'b1;
                            8'h0F:   sht_d[6] = 1'b1;
                            8'h11:   sht_d[7] = 1'b1;
                            8'h13:   sht_d[8] = 1'b1;
                            default: err_d    = 1'b1;
                        endcase
                    end else begin
                        opc_d   = rx_dat_i;
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = ARG;
                    end
                end
            end
            ARG: begin
                if (rx_stb_i) begin
                    timer_d = '0;
                    arg_d   = {rx_dat_i, arg_q[23:8]};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                        if (opc_q[7:6] == 2'b11) begin
                            if (opc_q[1:0] == 2'b11 || {1'b0, opc_q[5:2]} >= STAGES_L) begin
                                err_d = 1'b1;
                            end else begin
                                lng_d[opc_q[1:0]] = 1'b1;
                                cmd_d = full_arg;
                                stg_d = opc_q[2+:STG_W];
                            end
                        end else begin
                            cmd_d = full_arg;
                            case (opc_q)
                                8'h80:   lng_d[3] = 1'b1;
                                8'h81:   lng_d[4] = 1'b1;
                                8'h82:   lng_d[5] = 1'b1;
                                8'h9E:   lng_d[6] = 1'b1;
                                8'h9F:   lng_d[7] = 1'b1;
                                default: begin
                                    err_d = 1'b1;
                                    cmd_d = cmd_q;
                                end
                            endcase
                        end
                    end
                end else if (TMO_CYC > 0 && timer_q == TW'(TMO_LAST)) begin
                    // A byte on this same cycle is taken by the branch above instead.
                    state_d = IDLE;
                    err_d   = 1'b1;
                    arg_d   = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            opc_q   <= '0;
            arg_q   <= '0;
            cmd_q   <= '0;
            stg_q   <= '0;
            sht_q   <= '0;
            lng_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            opc_q   <= opc_d;
            arg_q   <= arg_d;
            cmd_q   <= cmd_d;
            stg_q   <= stg_d;
            sht_q   <= sht_d;
            lng_q   <= lng_d;
            err_q   <= err_d;
        end
    end

    assign sht_stb_o = sht_q;
    assign lng_stb_o = lng_q;
    assign cmd_o     = cmd_q;
    assign stg_o     = stg_q;
    assign stb_o     = (|sht_q) | (|lng_q);
    assign err_o     = err_q;
    assign busy_o    = (state_q == ARG);

endmodule

// File: tb/tb_indec_stream.sv
// Bench for indec_stream: two instances (STAGES=4 and STAGES=2, short timeout)
// share one byte stream; directed vectors with hand-computed expectations.
module tb_indec_stream;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_stb = 1'b0;
    logic [7:0]  rx_dat = 8'h00;

    logic [8:0]  sht_a, sht_b;
    logic [7:0]  lng_a, lng_b;
    logic [31:0] cmd_a, cmd_b;
    logic [1:0]  stg_a;
    logic [0:0]  stg_b;
    logic        stb_a, stb_b, err_a, err_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;
    int err_cnt_a = 0, stb_cnt_a = 0, sft_cnt_a = 0;

    always #5 clk = ~clk;

    indec_stream #(.STAGES(4), .TMO_CYC(TMO)) u_dut4 (
        .clk_i(clk), .rst_in(rst_n), .rx_stb_i(rx_stb), .rx_dat_i(rx_dat),
        .sht_stb_o(sht_a), .lng_stb_o(lng_a), .cmd_o(cmd_a), .stg_o(stg_a),
        .stb_o(stb_a), .err_o(err_a), .busy_o(busy_a)
    );

    indec_stream #(.STAGES(2), .TMO_CYC(TMO)) u_dut2 (
        .clk_i(clk), .rst_in(rst_n), .rx_stb_i(rx_stb), .rx_dat_i(rx_dat),
        .sht_stb_o(sht_b), .lng_stb_o(lng_b), .cmd_o(cmd_b), .stg_o(stg_b),
        .stb_o(stb_b), .err_o(err_b), .busy_o(busy_b)
    );

    // Every cycle: at most one strobe bit, stb_o equals the OR of them; tally pulses.
    always @(negedge clk) begin
        checks++;
        if ($countones({sht_a, lng_a}) > 1 || stb_a !== (|{sht_a, lng_a})) begin
            errors++;
            $display("FAIL strobe_shape t=%0t sht=%h lng=%h stb=%b required onehot0 and stb=OR", $time, sht_a, lng_a, stb_a);
        end
        err_cnt_a += int'(err_a);
        stb_cnt_a += int'(stb_a);
        sft_cnt_a += int'(sht_a[0]);
    end

    // Called at posedge+1; returns at posedge+1 after the byte was captured.
    task automatic send(input logic [7:0] b);
        rx_stb = 1'b1;
        rx_dat = b;
        @(posedge clk);
        #1;
        rx_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_long(input logic [7:0] opc, input logic [31:0] arg);
        send(opc);
        for (int k = 0; k < 4; k++) send(arg[8*k+:8]);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sht_a !== 9'h0 || lng_a !== 8'h0 || stb_a !== 1'b0) begin errors++; $display("FAIL reset_strobes sht=%h lng=%h stb=%b required 0", sht_a, lng_a, stb_a); end
        checks++; if (cmd_a !== 32'h0 || stg_a !== 2'd0) begin errors++; $display("FAIL reset_cmd cmd=%h stg=%0d required 0", cmd_a, stg_a); end
        checks++; if (err_a !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_flags err=%b busy=%b/%b required 0", err_a, busy_a, busy_b); end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_short;
        logic [7:0] ops [9] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h0F, 8'h11, 8'h13};
        send(8'h02);
        checks++; if (sht_a !== 9'h004 || stb_a !== 1'b1) begin errors++; $display("FAIL short_id sht=%h stb=%b required 004/1", sht_a, stb_a); end
        checks++; if (cmd_a !== 32'h0) begin errors++; $display("FAIL short_id_cmd cmd=%h required 0", cmd_a); end
        idle(1);
        checks++; if (sht_a !== 9'h000 || stb_a !== 1'b0) begin errors++; $display("FAIL short_id_width sht=%h stb=%b required 000/0", sht_a, stb_a); end
        for (int i = 0; i < 9; i++) begin
            send(ops[i]);
            checks++;
            if (sht_a !== (9'h001 << i) || lng_a !== 8'h0 || err_a !== 1'b0) begin
                errors++;
                $display("FAIL short_map op=%h sht=%h lng=%h err=%b required sht=%h", ops[i], sht_a, lng_a, err_a, 9'h001 << i);
            end
        end
        send(8'h03);
        checks++; if (err_a !== 1'b1 || stb_a !== 1'b0) begin errors++; $display("FAIL short_unknown err=%b stb=%b required 1/0", err_a, stb_a); end
        idle(1);
    endtask

    task automatic test_long;
        logic [7:0] b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        send(8'hC4);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL long_busy_opc busy=%b required 1", busy_a); end
        for (int i = 0; i < 3; i++) send(b[i]);
        checks++; if (busy_a !== 1'b1 || lng_a !== 8'h0) begin errors++; $display("FAIL long_busy_args busy=%b lng=%h required 1/00", busy_a, lng_a); end
        send(b[3]);
        checks++; if (lng_a !== 8'h01 || stb_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL long_mask lng=%h stb=%b busy=%b required 01/1/0", lng_a, stb_a, busy_a); end
        checks++; if (cmd_a !== 32'h12345678 || stg_a !== 2'd1) begin errors++; $display("FAIL long_mask_arg cmd=%h stg=%0d required 12345678/1", cmd_a, stg_a); end
        checks++; if (lng_b !== 8'h01 || cmd_b !== 32'h12345678 || stg_b !== 1'b1) begin errors++; $display("FAIL long_mask_s2 lng=%h cmd=%h stg=%0d required 01/12345678/1", lng_b, cmd_b, stg_b); end
        idle(1);
        checks++; if (lng_a !== 8'h0 || cmd_a !== 32'h12345678) begin errors++; $display("FAIL long_hold lng=%h cmd=%h required 00/12345678", lng_a, cmd_a); end
    endtask

    task automatic test_stage_cfg;
        // C9: set_val on stage 2 -> fine with 4 stages, bad with 2.
        send_long(8'hC9, 32'hDDCCBBAA);
        checks++; if (lng_a !== 8'h02 || cmd_a !== 32'hDDCCBBAA || stg_a !== 2'd2) begin errors++; $display("FAIL stage_val lng=%h cmd=%h stg=%0d required 02/DDCCBBAA/2", lng_a, cmd_a, stg_a); end
        checks++; if (err_b !== 1'b1 || lng_b !== 8'h0 || cmd_b !== 32'h12345678 || stg_b !== 1'b1) begin errors++; $display("FAIL stage_val_s2 err=%b lng=%h cmd=%h stg=%0d required 1/00/12345678/1", err_b, lng_b, cmd_b, stg_b); end
        idle(1);
    endtask

    task automatic test_bad_stage;
        send_long(8'hD0, 32'h44332211);
        checks++; if (err_a !== 1'b1 || lng_a !== 8'h0 || cmd_a !== 32'hDDCCBBAA || stg_a !== 2'd2) begin errors++; $display("FAIL bad_stage err=%b lng=%h cmd=%h stg=%0d required 1/00/DDCCBBAA/2", err_a, lng_a, cmd_a, stg_a); end
        checks++; if (err_b !== 1'b1 || lng_b !== 8'h0 || cmd_b !== 32'h12345678 || stg_b !== 1'b1) begin errors++; $display("FAIL bad_stage_s2 err=%b lng=%h cmd=%h stg=%0d required 1/00/12345678/1", err_b, lng_b, cmd_b, stg_b); end
        send_long(8'hC3, 32'h55555555);
        checks++; if (err_a !== 1'b1 || lng_a !== 8'h0 || cmd_a !== 32'hDDCCBBAA) begin errors++; $display("FAIL bad_sel err=%b lng=%h cmd=%h required 1/00/DDCCBBAA", err_a, lng_a, cmd_a); end
        send_long(8'hCE, 32'h0BADF00D);
        checks++; if (lng_a !== 8'h04 || stg_a !== 2'd3 || cmd_a !== 32'h0BADF00D) begin errors++; $display("FAIL cfg_stage3 lng=%h stg=%0d cmd=%h required 04/3/0BADF00D", lng_a, stg_a, cmd_a); end
        idle(1);
    endtask

    task automatic test_long_map;
        logic [7:0] ops [5] = '{8'h80, 8'h81, 8'h82, 8'h9E, 8'h9F};
        logic [31:0] arg;
        for (int i = 0; i < 5; i++) begin
            arg = 32'hA0B0C0D0 + 32'(i);
            send_long(ops[i], arg);
            checks++;
            if (lng_a !== (8'h08 << i) || cmd_a !== arg || err_a !== 1'b0) begin
                errors++;
                $display("FAIL long_map op=%h lng=%h cmd=%h err=%b required lng=%h cmd=%h", ops[i], lng_a, cmd_a, err_a, 8'h08 << i, arg);
            end
        end
        send_long(8'hA5, 32'h01020304);
        checks++; if (err_a !== 1'b1 || lng_a !== 8'h0 || cmd_a !== 32'hA0B0C0D4) begin errors++; $display("FAIL long_unknown err=%b lng=%h cmd=%h required 1/00/A0B0C0D4", err_a, lng_a, cmd_a); end
        idle(1);
    endtask

    task automatic test_timeout;
        send(8'h81);
        send(8'hAA);
        idle(TMO - 1);
        checks++; if (busy_a !== 1'b1 || err_a !== 1'b0) begin errors++; $display("FAIL tmo_early busy=%b err=%b required 1/0", busy_a, err_a); end
        idle(1);
        checks++; if (err_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL tmo_fire err=%b busy=%b required 1/0", err_a, busy_a); end
        idle(1);
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL tmo_width err=%b required 0", err_a); end
        send(8'h01);
        checks++; if (sht_a !== 9'h002 || cmd_a !== 32'hA0B0C0D4) begin errors++; $display("FAIL tmo_recover sht=%h cmd=%h required 002/A0B0C0D4", sht_a, cmd_a); end
        // Byte arriving on the timeout cycle is accepted.
        send(8'h81);
        send(8'h11);
        idle(TMO - 1);
        send(8'h22);
        checks++; if (busy_a !== 1'b1 || err_a !== 1'b0) begin errors++; $display("FAIL tmo_byte_wins busy=%b err=%b required 1/0", busy_a, err_a); end
        send(8'h33);
        send(8'h44);
        checks++; if (lng_a !== 8'h10 || cmd_a !== 32'h44332211) begin errors++; $display("FAIL tmo_byte_cmd lng=%h cmd=%h required 10/44332211", lng_a, cmd_a); end
        idle(1);
    endtask

    task automatic test_reset_mid;
        send(8'h80);
        send(8'h01);
        send(8'h02);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        checks++; if (busy_a !== 1'b0 || cmd_a !== 32'h0 || stg_a !== 2'd0) begin errors++; $display("FAIL rst_mid busy=%b cmd=%h stg=%0d required 0/0/0", busy_a, cmd_a, stg_a); end
        send_long(8'h80, 32'h00000001);
        checks++; if (lng_a !== 8'h08 || cmd_a !== 32'h1 || err_a !== 1'b0) begin errors++; $display("FAIL rst_mid_div lng=%h cmd=%h err=%b required 08/1/0", lng_a, cmd_a, err_a); end
        idle(1);
    endtask

    task automatic test_back_to_back;
        int e0, s0;
        idle(1);
        e0 = err_cnt_a;
        s0 = stb_cnt_a;
        send(8'h03);
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL b2b_short_err err=%b required 1", err_a); end
        send_long(8'hA5, 32'h04030201);
        checks++; if (err_a !== 1'b1 || lng_a !== 8'h0) begin errors++; $display("FAIL b2b_long_err err=%b lng=%h required 1/00", err_a, lng_a); end
        idle(2);
        checks++; if (err_cnt_a - e0 != 2 || stb_cnt_a - s0 != 0) begin errors++; $display("FAIL b2b_counts err_pulses=%0d stb_pulses=%0d required 2/0", err_cnt_a - e0, stb_cnt_a - s0); end
    endtask

    task automatic test_zero_bytes;
        int f0;
        f0 = sft_cnt_a;
        repeat (5) send(8'h00);
        idle(2);
        checks++; if (sft_cnt_a - f0 != 5) begin errors++; $display("FAIL zero_sft pulses=%0d required 5", sft_cnt_a - f0); end
        send_long(8'h80, 32'h00000000);
        checks++; if (lng_a !== 8'h08 || cmd_a !== 32'h0) begin errors++; $display("FAIL zero_args lng=%h cmd=%h required 08/0", lng_a, cmd_a); end
        idle(2);
        checks++; if (sft_cnt_a - f0 != 5) begin errors++; $display("FAIL zero_args_sft pulses=%0d required 5", sft_cnt_a - f0); end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_stage_cfg();
        test_bad_stage();
        test_long_map();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_zero_bytes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
